// File: rtl/booth_multiplier_if.sv
// Handshake and operand/product bundle between the execute controller and the Booth multiplier.
// The controller drives start and the operands; the multiplier returns busy, done and the product.
interface booth_multiplier_if #(
  parameter int unsigned N = 32
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_multiplier.sv
// Iterative signed radix-2 Booth multiplier: one add/sub plus arithmetic shift per clock,
// N steps per product, with the result held stable until the next product completes.
module booth_multiplier #(
  parameter int unsigned N = 32
) (
  input  logic              clk,
  input  logic              reset,
  booth_multiplier_if.slave bus
);
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned PW = 2 * N;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic signed [N:0]   a, a_next, m, m_next, a_sum;
  logic [N-1:0]        q, q_next;
  logic                q_1, q_1_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [PW-1:0]       product, product_next;
  logic                busy, done;

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      a       <= a_next;
      m       <= m_next;
      q       <= q_next;
      q_1     <= q_1_next;
      cnt     <= cnt_next;
      product <= product_next;
      busy    <= (state_next != IDLE);
      done    <= (state_next == DONE);
    end
  end

  // Next-state and Booth step: add/sub on {Q[0],Q_1}, then shift {A,Q,Q_1} right keeping A's sign.
  always_comb begin
    state_next   = state;
    a_next       = a;
    m_next       = m;
    q_next       = q;
    q_1_next     = q_1;
    cnt_next     = cnt;
    product_next = product;
    a_sum        = a;

    case ({q[0], q_1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase

    case (state)
      IDLE: begin
        if (bus.start) begin
          a_next     = '0;
          q_next     = bus.multiplier;
          q_1_next   = 1'b0;
          m_next     = {bus.multiplicand[N-1], bus.multiplicand};
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        a_next   = {a_sum[N], a_sum[N:1]};
        q_next   = {a_sum[0], q[N-1:1]};
        q_1_next = q[0];
        cnt_next = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_next   = DONE;
          product_next = {a_next[N-1:0], q_next};
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product;
endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed sign/extreme cases, start-while-busy,
// mid-operation reset, back-to-back issue and a randomized sweep against a 64-bit signed model.
module tb_booth_multiplier;
  localparam int unsigned N = 32;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   cyc;

  booth_multiplier_if #(.N(N)) bus ();

  booth_multiplier #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint x;
    longint y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  // Issue one operation and follow it to completion; operands are scrambled right after accept.
  task automatic run_op(input logic [31:0] mc, input logic [31:0] mp,
                        output logic [63:0] prod, output int busy_cyc,
                        output int done_cnt, output int done_at, output bit timeout);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = mc;
    bus.multiplier   = mp;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    busy_cyc = 0;
    done_cnt = 0;
    done_at  = -1;
    prod     = '0;
    timeout  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) begin
        timeout = 1'b0;
        break;
      end
      busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        done_at = busy_cyc;
        prod    = bus.product;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_op(input string name, input logic [31:0] mc, input logic [31:0] mp,
                          input logic [63:0] exp);
    logic [63:0] prod;
    int bc, dc, da;
    bit to;
    run_op(mc, mp, prod, bc, dc, da, to);
    tests++;
    if (to || dc !== 1 || prod !== exp) begin
      fails++;
      $display("FAIL %s: product=%h done_count=%0d timeout=%0b, required product=%h done_count=1",
               name, prod, dc, to, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0",
               bus.busy, bus.done, bus.product);
    end
  endtask

  task automatic test_basic();
    logic [63:0] prod;
    int bc, dc, da;
    bit to;
    run_op(32'd7, 32'd3, prod, bc, dc, da, to);
    tests++;
    if (prod !== 64'h15 || dc !== 1 || to) begin
      fails++;
      $display("FAIL basic_product: got %h dc=%0d, required 0000000000000015 dc=1", prod, dc);
    end
    tests++;
    if (bc !== 33) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, required 33", bc);
    end
    tests++;
    if (da !== 33) begin
      fails++;
      $display("FAIL basic_done_latency: done in busy cycle %0d, required 33", da);
    end
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (bus.product !== 64'h15 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL basic_hold: product=%h busy=%b done=%b, required 15 0 0",
               bus.product, bus.busy, bus.done);
    end
  endtask

  task automatic test_signs();
    check_op("neg_m",   32'hFFFF_FFFB, 32'd3,         64'hFFFF_FFFF_FFFF_FFF1);
    check_op("neg_q",   32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    check_op("neg_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1);
  endtask

  task automatic test_extremes();
    check_op("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    check_op("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    check_op("min_max", 32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
  endtask

  task automatic test_start_while_busy();
    int dc = 0;
    logic [63:0] prod = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd6; bus.multiplier = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd9; bus.multiplier = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dc++;
        prod = bus.product;
      end
    end
    tests++;
    if (dc !== 1 || prod !== 64'd42) begin
      fails++;
      $display("FAIL start_ignored: done_count=%0d product=%h, required 1 and 000000000000002a", dc, prod);
    end
  endtask

  task automatic test_reset_mid();
    int dc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.multiplicand = 32'd100; bus.multiplier = 32'd100;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== 64'h0) begin
      fails++;
      $display("FAIL reset_mid_abort: busy=%b done=%b product=%h, required 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dc++;
    end
    tests++;
    if (dc !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: activity cycles=%0d, required 0", dc);
    end
    check_op("after_reset", 32'd2, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC);
  endtask

  // Start held high: each done is followed by a fresh accept, so completions are N+2 cycles apart.
  task automatic test_back_to_back();
    logic [63:0] expq[$];
    logic [31:0] mc, mp;
    int last_done = -1;
    int seen = 0;
    logic [63:0] exp;
    @(negedge clk);
    mc = $urandom; mp = $urandom;
    bus.multiplicand = mc; bus.multiplier = mp;
    expq.push_back(ref_mul(mc, mp));
    bus.start = 1'b1;
    for (int i = 0; i < 400 && seen < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 64'hDEAD;
        tests++;
        if (bus.product !== exp) begin
          fails++;
          $display("FAIL b2b_product[%0d]: got %h, required %h", seen, bus.product, exp);
        end
        if (last_done >= 0) begin
          tests++;
          if (cyc - last_done !== 34) begin
            fails++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, required 34", seen, cyc - last_done);
          end
        end
        last_done = cyc;
        seen++;
        mc = $urandom; mp = $urandom;
        bus.multiplicand = mc; bus.multiplier = mp;
        expq.push_back(ref_mul(mc, mp));
      end
    end
    bus.start = 1'b0;
    tests++;
    if (seen !== 6) begin
      fails++;
      $display("FAIL b2b_count: got %0d products, required 6", seen);
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] mc, mp;
    logic [31:0] special [5];
    special[0] = 32'h0; special[1] = 32'h1; special[2] = 32'hFFFF_FFFF;
    special[3] = 32'h8000_0000; special[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      mc = $urandom;
      mp = $urandom;
      if ($urandom_range(0, 7) == 0) mc = special[$urandom_range(0, 4)];
      if ($urandom_range(0, 7) == 0) mp = special[$urandom_range(0, 4)];
      check_op("random", mc, mp, ref_mul(mc, mp));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_signs();
    test_extremes();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
